// File: rtl/vcnpu_dram_pkg.sv
// ============================================================================
// Module : vcnpu_dram_pkg
// Brief  : Shared types and widths for the DRAM read-port arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vcnpu_dram_pkg;

    localparam int c_ADDR_W      = 32;
    localparam int c_LEN_W       = 16;
    localparam int c_DEF_MAX_LEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_BAD_LEN = 2'b01,
        ERR_STRAY   = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

endpackage

`default_nettype wire

// File: rtl/vcnpu_rr_pick.sv
// ============================================================================
// Module : vcnpu_rr_pick
// Brief  : Combinational round-robin selector: first valid at/after pointer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vcnpu_rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Walk offsets from farthest to nearest so the nearest valid wins.
    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (i_valid[j]) begin
                o_grant    = '0;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
                o_any      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vcnpu_dram_arbiter.sv
// ============================================================================
// Module : vcnpu_dram_arbiter
// Brief  : Round-robin arbiter sharing one DRAM read port among NREQ clients.
//          Optional watchdog: define VCNPU_DRAM_ARB_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vcnpu_dram_arbiter
    import vcnpu_dram_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int DATA_W      = 16,
    parameter int MAX_LEN     = c_DEF_MAX_LEN,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*c_ADDR_W-1:0] req_addr,
    input  logic [NREQ*c_LEN_W-1:0]  req_len,
    output logic [NREQ-1:0]          req_grant,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_last,
    output logic [NREQ-1:0]          done,
    output logic                     dram_req,
    output logic [c_ADDR_W-1:0]      dram_addr,
    output logic [c_LEN_W-1:0]       dram_len,
    input  logic                     dram_ack,
    input  logic                     dram_data_valid,
    input  logic [DATA_W-1:0]        dram_data_in,
    output logic                     busy,
    output logic                     err,
    output logic [1:0]               err_code,
    input  logic                     err_clr
);

    localparam int c_IDX_W = $clog2(NREQ);

    arb_state_t           r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [c_IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [c_ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [c_LEN_W-1:0]   r_len, w_len_nxt;
    logic [c_LEN_W-1:0]   r_cnt, w_cnt_nxt;
    logic [NREQ-1:0]      r_grant, w_grant_nxt;
    logic [NREQ-1:0]      r_done, w_done_nxt;
    logic [NREQ-1:0]      r_rsp_valid, w_rv_nxt;
    logic [DATA_W-1:0]    r_rsp_data, w_data_nxt;
    logic                 r_rsp_last, w_last_nxt;
    logic                 r_err;
    err_code_t            r_err_code, w_err_new;

    logic [NREQ-1:0]      w_pick_grant;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic                 w_pick_any;
    logic [c_ADDR_W-1:0]  w_req_addr;
    logic [c_LEN_W-1:0]   w_req_len;
    logic                 w_len_ok;
    logic [NREQ-1:0]      w_owner_oh;
    logic [c_LEN_W-1:0]   w_cnt_inc;
    logic                 w_beat;
    logic                 w_timeout;

    vcnpu_rr_pick #(
        .N     (NREQ),
        .IDX_W (c_IDX_W)
    ) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_req_addr = req_addr[c_ADDR_W*int'(w_pick_idx) +: c_ADDR_W];
    assign w_req_len  = req_len[c_LEN_W*int'(w_pick_idx) +: c_LEN_W];
    assign w_len_ok   = (w_req_len != '0) && (w_req_len <= c_LEN_W'(MAX_LEN));
    assign w_owner_oh = NREQ'(1) << r_owner;
    assign w_cnt_inc  = r_cnt + c_LEN_W'(1);
    // A beat coincident with the acknowledge already belongs to the burst.
    assign w_beat     = dram_data_valid &&
                        ((r_state == ST_ISSUE && dram_ack) || r_state == ST_DATA);

`ifdef VCNPU_DRAM_ARB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [c_TMO_W-1:0] r_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (r_state == ST_IDLE || w_beat) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + c_TMO_W'(1);
        end
    end

    // Progress in the limit cycle (ack or beat) wins over the watchdog.
    assign w_timeout = (r_state != ST_IDLE) &&
                       (r_tmo >= c_TMO_W'(TIMEOUT_CYC - 1)) &&
                       !dram_data_valid &&
                       !(r_state == ST_ISSUE && dram_ack);
`else
    localparam bit c_TMO_OFF = (TIMEOUT_CYC > 0);
    assign w_timeout = c_TMO_OFF & 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_addr_nxt  = r_addr;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = '0;
        w_done_nxt  = '0;
        w_rv_nxt    = '0;
        w_data_nxt  = r_rsp_data;
        w_last_nxt  = 1'b0;
        w_err_new   = ERR_NONE;

        case (r_state)
            ST_IDLE: begin
                if (dram_data_valid) begin
                    w_err_new = ERR_STRAY;
                end
                if (w_pick_any) begin
                    w_grant_nxt = w_pick_grant;
                    w_owner_nxt = w_pick_idx;
                    w_addr_nxt  = w_req_addr;
                    w_len_nxt   = w_req_len;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = (w_pick_idx == c_IDX_W'(NREQ - 1)) ?
                                  '0 : w_pick_idx + c_IDX_W'(1);
                    if (w_len_ok) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        // Rejected burst completes immediately without DRAM traffic.
                        w_done_nxt = w_pick_grant;
                        w_err_new  = ERR_BAD_LEN;
                    end
                end
            end
            ST_ISSUE: begin
                if (dram_ack) begin
                    w_state_nxt = ST_DATA;
                end else if (dram_data_valid) begin
                    w_err_new = ERR_STRAY;
                end
            end
            ST_DATA: begin
                w_state_nxt = ST_DATA;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_beat) begin
            w_cnt_nxt  = w_cnt_inc;
            w_rv_nxt   = w_owner_oh;
            w_data_nxt = dram_data_in;
            if (w_cnt_inc == r_len) begin
                w_last_nxt  = 1'b1;
                w_done_nxt  = w_owner_oh;
                w_state_nxt = ST_IDLE;
            end
        end

        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = w_owner_oh;
            w_err_new   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_addr      <= w_addr_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_rsp_valid <= w_rv_nxt;
            r_rsp_data  <= w_data_nxt;
            r_rsp_last  <= w_last_nxt;
            // First error is kept; a clear in the same cycle lets the new one in.
            if (w_err_new != ERR_NONE && (!r_err || err_clr)) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_new;
            end else if (err_clr) begin
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
            end
        end
    end

    assign req_grant = r_grant;
    assign done      = r_done;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_last  = r_rsp_last;
    assign dram_req  = (r_state == ST_ISSUE);
    assign dram_addr = dram_req ? r_addr : '0;
    assign dram_len  = dram_req ? r_len : '0;
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_vcnpu_dram_arbiter.sv
// ============================================================================
// Module : tb_vcnpu_dram_arbiter
// Brief  : Self-checking bench with a transaction-level arbiter model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vcnpu_dram_arbiter;
    import vcnpu_dram_pkg::*;

    localparam int NREQ    = 3;
    localparam int DATA_W  = 16;
    localparam int MAX_LEN = 64;
    localparam int TMO     = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*32-1:0]   req_addr = '0;
    logic [NREQ*16-1:0]   req_len = '0;
    logic [NREQ-1:0]      req_grant, rsp_valid, done;
    logic [DATA_W-1:0]    rsp_data;
    logic                 rsp_last, dram_req, busy, err;
    logic [31:0]          dram_addr;
    logic [15:0]          dram_len;
    logic                 dram_ack = 1'b0;
    logic                 dram_data_valid = 1'b0;
    logic [DATA_W-1:0]    dram_data_in = '0;
    logic [1:0]           err_code;
    logic                 err_clr = 1'b0;

    always #5 clk = ~clk;

    vcnpu_dram_arbiter #(
        .NREQ(NREQ), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_len(req_len), .req_grant(req_grant), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .done(done),
        .dram_req(dram_req), .dram_addr(dram_addr), .dram_len(dram_len),
        .dram_ack(dram_ack), .dram_data_valid(dram_data_valid),
        .dram_data_in(dram_data_in), .busy(busy), .err(err),
        .err_code(err_code), .err_clr(err_clr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: one outstanding burst, rotating priority pointer.
    bit              m_active, m_acked, m_err;
    int              m_owner, m_len, m_beats, m_ptr, m_tmo;
    logic [31:0]     m_addr;
    logic [1:0]      m_code;
    logic [NREQ-1:0] e_grant, e_done, e_rv;
    bit              e_last;
    logic [15:0]     e_data;

    // Requesters and DRAM stub.
    bit [NREQ-1:0]   pend = '0;
    logic [31:0]     paddr [NREQ];
    logic [15:0]     plen  [NREQ];
    int              stub_mode = 0;   // 0 prompt, 1 random, 2 silent, 3 manual
    bit              auto_repend = 0;

    // Observations of the DUT for directed scenarios.
    int              grant_q[$];
    int              obs_beats [NREQ];
    int              obs_dreq, obs_done_cnt;
    logic [31:0]     obs_addr;
    logic [15:0]     obs_len, obs_last_data;
    bit              obs_rv_any;

    task automatic model_reset();
        m_active = 0; m_acked = 0; m_err = 0; m_code = 2'b00;
        m_owner = 0; m_len = 0; m_beats = 0; m_ptr = 0; m_tmo = 0; m_addr = '0;
        e_grant = '0; e_done = '0; e_rv = '0; e_last = 0; e_data = '0;
    endtask

    task automatic model_edge();
        logic [1:0] newerr;
        bit beat, issue, tmo_fire;
        int g;
        newerr = 2'b00; beat = 0; issue = 0; tmo_fire = 0; g = -1;
        e_grant = '0; e_done = '0; e_rv = '0; e_last = 0;
        if (!m_active) begin
            if (dram_data_valid) newerr = 2'b10;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            if (g >= 0) begin
                e_grant[g] = 1'b1;
                m_ptr   = (g + 1) % NREQ;
                m_owner = g;
                m_addr  = req_addr[32*g +: 32];
                m_len   = int'(req_len[16*g +: 16]);
                if (m_len >= 1 && m_len <= MAX_LEN) begin
                    m_active = 1; m_acked = 0; m_beats = 0; m_tmo = 0;
                end else begin
                    e_done[g] = 1'b1;
                    newerr = 2'b01;
                end
            end
        end else begin
            issue = !m_acked;
`ifdef VCNPU_DRAM_ARB_TIMEOUT_EN
            tmo_fire = (m_tmo >= TMO - 1) && !dram_data_valid && !(issue && dram_ack);
`endif
            if (tmo_fire) begin
                m_active = 0;
                e_done[m_owner] = 1'b1;
                newerr = 2'b11;
            end else begin
                if (issue) begin
                    if (dram_ack) begin
                        m_acked = 1;
                        beat = dram_data_valid;
                    end else if (dram_data_valid) begin
                        newerr = 2'b10;
                    end
                end else begin
                    beat = dram_data_valid;
                end
                if (beat) begin
                    m_beats++;
                    e_rv[m_owner] = 1'b1;
                    e_data = dram_data_in;
                    if (m_beats == m_len) begin
                        e_last = 1;
                        e_done[m_owner] = 1'b1;
                        m_active = 0;
                    end
                end
                m_tmo = beat ? 0 : m_tmo + 1;
            end
        end
        if (newerr != 2'b00 && (!m_err || err_clr)) begin
            m_err = 1; m_code = newerr;
        end else if (err_clr) begin
            m_err = 0; m_code = 2'b00;
        end
    endtask

    task automatic check_outputs();
        bit exp_dreq;
        exp_dreq = m_active && !m_acked;
        chk("req_grant", req_grant, e_grant);
        chk("done", done, e_done);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_last", rsp_last, e_last);
        chk("rsp_data", rsp_data, e_data);
        chk("dram_req", dram_req, exp_dreq);
        chk("dram_addr", dram_addr, exp_dreq ? m_addr : 32'h0);
        chk("dram_len", dram_len, exp_dreq ? m_len : 0);
        chk("busy", busy, m_active);
        chk("err", err, m_err);
        chk("err_code", err_code, m_code);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = pend[i];
            req_addr[32*i +: 32] = paddr[i];
            req_len[16*i +: 16]  = plen[i];
        end
    endtask

    task automatic drive_stub();
        case (stub_mode)
            0: begin
                dram_ack        = m_active && !m_acked;
                dram_data_valid = m_active && m_acked;
                dram_data_in    = 16'(m_beats);
            end
            1: begin
                dram_ack = (m_active && !m_acked) ? 1'($urandom % 2) : 1'b0;
                if (m_active && m_acked)
                    dram_data_valid = ($urandom % 3) != 0;
                else if (m_active)
                    dram_data_valid = dram_ack ? 1'($urandom % 2) : (($urandom % 20) == 0);
                else
                    dram_data_valid = (pend == '0) && (($urandom % 30) == 0);
                dram_data_in = 16'($urandom);
                err_clr      = ($urandom % 25) == 0;
            end
            2: begin
                dram_ack = 1'b0;
                dram_data_valid = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic new_random_reqs();
        int r;
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && ($urandom % 4) == 0) begin
                pend[i]  = 1'b1;
                paddr[i] = $urandom;
                r = int'($urandom % 16);
                plen[i]  = (r == 0) ? 16'd0 : (r == 1) ? 16'd65 :
                           (r == 2) ? 16'd64 : 16'(1 + $urandom % 6);
            end else if (pend[i] && ($urandom % 60) == 0) begin
                pend[i] = 1'b0;
            end
        end
    endtask

    task automatic clr_obs();
        grant_q.delete();
        for (int i = 0; i < NREQ; i++) obs_beats[i] = 0;
        obs_dreq = 0; obs_done_cnt = 0; obs_addr = '0; obs_len = '0;
        obs_last_data = '0; obs_rv_any = 0;
    endtask

    // One clock: model at the edge, compare at the falling edge, then drive.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        @(negedge clk);
        check_outputs();
        if (dram_req) begin obs_dreq++; obs_addr = dram_addr; obs_len = dram_len; end
        for (int i = 0; i < NREQ; i++) begin
            if (rsp_valid[i]) obs_beats[i]++;
            if (req_grant[i]) grant_q.push_back(i);
            if (e_grant[i] && !auto_repend) pend[i] = 1'b0;
        end
        if (rsp_valid != '0) obs_rv_any = 1;
        if (rsp_last) obs_last_data = rsp_data;
        if (done != '0) obs_done_cnt++;
        if (stub_mode == 1) new_random_reqs();
        drive_stub();
        drive_reqs();
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((pend != '0 || m_active) && b < 400) begin step(); b++; end
        chk("drain_bound", b < 400, 1'b1);
    endtask

    task automatic wait_grant(input string tag);
        int b;
        b = 0;
        while (grant_q.size() == 0 && b < 20) begin step(); b++; end
        chk(tag, grant_q.size() > 0, 1'b1);
    endtask

    task automatic clear_err();
        err_clr = 1'b1; step(); err_clr = 1'b0;
    endtask

    initial begin
        int b;
        int exp_order[6];
        exp_order = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < NREQ; i++) begin paddr[i] = '0; plen[i] = '0; end
        model_reset();
        clr_obs();
        step(); step();
        rst = 1'b0;
        step();

        // Single burst, prompt DRAM.
        clr_obs();
        pend[0] = 1'b1; paddr[0] = 32'h1000; plen[0] = 16'd4; drive_reqs();
        b = 0;
        while (obs_done_cnt == 0 && b < 40) begin step(); b++; end
        chk("t1_done_seen", obs_done_cnt, 1);
        chk("t1_addr", obs_addr, 32'h1000);
        chk("t1_len", obs_len, 16'd4);
        chk("t1_beats", obs_beats[0], 4);
        chk("t1_last_data", obs_last_data, 16'd3);
        step();
        chk("t1_busy_after", busy, 1'b0);

        // Fairness from a fresh pointer.
        rst = 1'b1; step(); rst = 1'b0; step();
        clr_obs();
        auto_repend = 1;
        for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b1; paddr[i] = 32'h100 * i; plen[i] = 16'd2; end
        drive_reqs();
        b = 0;
        while (grant_q.size() < 6 && b < 200) begin step(); b++; end
        auto_repend = 0;
        pend = '0; drive_reqs();
        chk("t2_grant_count", grant_q.size() >= 6, 1'b1);
        for (int i = 0; i < 6 && i < grant_q.size(); i++) chk("t2_order", grant_q[i], exp_order[i]);
        drain();

        // Illegal lengths.
        clr_obs();
        pend[1] = 1'b1; plen[1] = 16'd0; drive_reqs();
        wait_grant("t3a_grant");
        step();
        chk("t3a_err", err, 1'b1);
        chk("t3a_code", err_code, 2'b01);
        clear_err();
        chk("t3_err_cleared", err, 1'b0);
        clr_obs();
        pend[1] = 1'b1; plen[1] = 16'd65; drive_reqs();
        wait_grant("t3b_grant");
        step();
        chk("t3b_code", err_code, 2'b01);
        chk("t3b_no_dram", obs_dreq, 0);
        clear_err();

        // Stray beat while idle.
        clr_obs();
        stub_mode = 3;
        dram_data_valid = 1'b1; dram_data_in = 16'hBEEF;
        step();
        dram_data_valid = 1'b0;
        step();
        chk("t4_code", err_code, 2'b10);
        chk("t4_no_rsp", obs_rv_any, 1'b0);
        clear_err();

        // Reset mid-burst, then arbitration restarts at pointer 0.
        stub_mode = 0;
        clr_obs();
        pend[1] = 1'b1; plen[1] = 16'd8; paddr[1] = 32'h2000; drive_reqs();
        b = 0;
        while (obs_beats[1] < 2 && b < 30) begin step(); b++; end
        chk("t5_two_beats", obs_beats[1], 2);
        rst = 1'b1;
        #1;
        chk("t5_async_busy", busy, 1'b0);
        chk("t5_async_dram_req", dram_req, 1'b0);
        step();
        rst = 1'b0;
        clr_obs();
        pend[1] = 1'b1; pend[2] = 1'b1; plen[1] = 16'd2; plen[2] = 16'd2; drive_reqs();
        wait_grant("t5_grant");
        if (grant_q.size() > 0) chk("t5_first_grant", grant_q[0], 1);
        drain();

`ifdef VCNPU_DRAM_ARB_TIMEOUT_EN
        // Watchdog: DRAM never acknowledges.
        clr_obs();
        stub_mode = 2;
        pend[0] = 1'b1; plen[0] = 16'd4; drive_reqs();
        b = 0;
        while (obs_done_cnt == 0 && b < 60) begin step(); b++; end
        chk("t6_dreq_cycles", obs_dreq, TMO);
        chk("t6_code", err_code, 2'b11);
        clear_err();
        stub_mode = 0;
`endif

        // Randomized traffic against the model.
        stub_mode = 1;
        for (int n = 0; n < 3000; n++) step();
        stub_mode = 0;
        err_clr = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/vcnpu_dram_arbiter.md
# vcnpu_dram_arbiter

Round-robin arbiter that shares the single `vcnpu_top` DRAM read port (`dram_req/dram_addr/dram_len/dram_ack/dram_data_valid/dram_data_in`) between NREQ on-chip requesters (e.g. bitstream fetch, weight loader, reference-frame loader).
- Sequences one burst at a time: issue, acknowledge, beat counting, completion.
- Steers returned beats to the granted requester.
- Flags protocol violations on a sticky error output, which feeds `vcnpu_top.error`.

## Interface
Parameters:
- `NREQ`, 3, number of requesters (2..8)
- `DATA_W`, 16, DRAM beat width
- `MAX_LEN`, 64, largest legal burst length in beats
- `TIMEOUT_CYC`, 256, watchdog limit in cycles (used only with the timeout macro)

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  per-requester request; held with addr/len stable until `req_grant`
- `req_addr`  in  NREQ*32  packed start addresses; requester i uses bits [32i+31:32i]
- `req_len`  in  NREQ*16  packed burst lengths in beats
- `req_grant`  out  NREQ  one-hot, 1-cycle acceptance pulse
- `rsp_valid`  out  NREQ  one-hot beat strobe to the owner
- `rsp_data`  out  DATA_W  beat data, shared by all requesters
- `rsp_last`  out  1  final beat of the burst
- `done`  out  NREQ  one-hot, 1-cycle burst-complete pulse
- `dram_req`  out  1  burst request to DRAM
- `dram_addr`  out  32  burst address, valid while `dram_req`=1
- `dram_len`  out  16  burst length, valid while `dram_req`=1
- `dram_ack`  in  1  DRAM accepts the request
- `dram_data_valid`  in  1  DRAM beat strobe
- `dram_data_in`  in  DATA_W  DRAM beat data
- `busy`  out  1  state ≠ IDLE
- `err`  out  1  sticky error flag
- `err_code`  out  2  first error recorded: 01 = bad length, 10 = stray beat, 11 = timeout
- `err_clr`  in  1  clears `err` and `err_code`

## Operation
Reset:
- All outputs are 0.
- State is IDLE, RR pointer is 0, beat counter is 0.
- Reset mid-burst abandons the burst; no `done` is issued.

States:
- **IDLE**
  - If any `req_valid` is set, pick the first set bit at or after the RR pointer, wrapping around.
  - Pulse `req_grant[g]` and latch g, addr and len.
  - Set the RR pointer to (g+1) mod NREQ.
  - Legal len (1..MAX_LEN): go to ISSUE.
  - Illegal len (0 or >MAX_LEN): in the same cycle, pulse `done[g]` with `rsp_last`=0; set err code 01; stay in IDLE. No DRAM traffic occurs.
- **ISSUE**
  - `dram_req`=1 with the latched addr/len, held until `dram_ack`.
  - On `dram_ack`, go to DATA; `dram_req` is 0 in the next cycle.
  - A `dram_data_valid` in the same cycle as `dram_ack` counts as beat 1.
- **DATA**
  - Each `dram_data_valid` increments the beat count and forwards the beat to the owner.
  - On beat == len, assert `rsp_last` and `done[g]` together with that beat, then return to IDLE.

Errors:
- **Stray beat (code 10):** `dram_data_valid` in IDLE, or in ISSUE before `dram_ack`. The beat is dropped.
- **Recording:** `err` is sticky. `err_code` holds the first error seen. `err_clr` clears both.
- **Clear vs. new error:** a new error in the same cycle as `err_clr` takes priority and is recorded.
- **No halt:** errors other than timeout do not stop arbitration.

## Timing
- Grant latency: `req_valid` sampled in IDLE at edge N gives `req_grant` and `dram_req` high during cycle N+1.
- Beat latency: `dram_data_valid` at edge N gives registered `rsp_valid`/`rsp_data` during cycle N+1.
- `done` and `rsp_last` are registered, aligned with the last `rsp_valid`.
- Back-to-back bursts: the next grant can occur in the cycle after `done`. Minimum gap between bursts is 1 IDLE cycle.
- Fairness: with all requesters permanently valid, grants rotate 0,1,2,0,…; no requester waits more than NREQ-1 bursts.
- A `req_valid` dropped before grant is legal and is simply not selected.

## Configuration
- `VCNPU_DRAM_ARB_TIMEOUT_EN` defined:
  - A counter resets on entry to ISSUE and on every beat.
  - When it reaches TIMEOUT_CYC in ISSUE or DATA: drop `dram_req`, pulse `done[g]` without `rsp_last`, set err code 11, go to IDLE.
- Not defined: no counter is instantiated, and the arbiter waits indefinitely for `dram_ack` and beats.

## Structure
- Package `vcnpu_dram_pkg`:
  - state enum (IDLE/ISSUE/DATA)
  - err_code enum
  - address and length widths
  - default MAX_LEN
- Sub-module `vcnpu_rr_pick`: combinational round-robin selector taking (valid vector, pointer) and returning a one-hot grant plus index. It is reused by later schedulers.

## Test plan
- Single request: req 0, addr 0x1000, len 4; DRAM stub acks 1 cycle after `dram_req` and returns data 0..3 → `dram_addr`=0x1000, `dram_len`=4; `rsp_valid[0]`×4 with data 0..3; `rsp_last` and `done[0]` on data 3; `busy` then 0.
- Fairness: all three requesters held valid, len 2 each → grant order 0,1,2,0,1,2; each `done` matches its grant.
- Illegal length: req 1, len 0, then a separate req 1 with len 65 → `done[1]` in the grant cycle each time, no `dram_req`, `err`=1, `err_code`=01; `err_clr` returns `err` to 0.
- Stray beat: `dram_data_valid` pulsed while IDLE → `err_code`=10, no `rsp_valid`.
- Timeout (macro on, TIMEOUT_CYC=16): `dram_ack` never asserted → `dram_req` drops after 16 cycles, `done[g]` asserted, `err_code`=11.
- Reset mid-burst: assert `rst` after beat 2 of 8 → all outputs 0; the next request is arbitrated from pointer 0.
